// File: rtl/fu_wb_queue_pkg.sv
// Shared types and widths for the writeback completion buffer.
// The width macros fall back to defaults only when the core has not defined them.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

package fu_pkg;

    typedef struct packed {
        logic                   wr_en;
        logic [`PRF_IDX_W-1:0]  tag;
        logic [63:0]            value;
        logic [`ROB_IDX_W:0]    rob_idx;
        logic [`BR_MASK_W-1:0]  br_mask;
    } wb_entry_t;

    localparam int WB_SRC_ALU  = 0;
    localparam int WB_SRC_MULT = 1;
    localparam int WB_SRC_LDST = 2;
    localparam int WB_SRC_BR   = 3;

endpackage

// File: rtl/fu_wb_queue_if.sv
// Source-side result handshake, branch resolution and CDB broadcast signals.
interface fu_wb_queue_if #(
    parameter int NSRC = 4
);
    localparam int SRC_W = $clog2(NSRC);

    logic [NSRC-1:0]                  src_vld_i;
    logic [NSRC-1:0]                  src_rdy_o;
    logic [NSRC-1:0]                  src_wr_en_i;
    logic [NSRC-1:0][`PRF_IDX_W-1:0]  src_tag_i;
    logic [NSRC-1:0][63:0]            src_value_i;
    logic [NSRC-1:0][`ROB_IDX_W:0]    src_rob_idx_i;
    logic [NSRC-1:0][`BR_MASK_W-1:0]  src_br_mask_i;
    logic                             rob_br_recovery_i;
    logic                             rob_br_pred_correct_i;
    logic [`BR_MASK_W-1:0]            rob_br_tag_fix_i;
    logic                             cdb_vld_o;
    logic                             cdb_wr_en_o;
    logic [`PRF_IDX_W-1:0]            cdb_tag_o;
    logic [63:0]                      cdb_value_o;
    logic [`ROB_IDX_W:0]              cdb_rob_idx_o;
    logic [SRC_W-1:0]                 cdb_src_o;

    modport master (
        output src_vld_i, src_wr_en_i, src_tag_i, src_value_i, src_rob_idx_i,
               src_br_mask_i, rob_br_recovery_i, rob_br_pred_correct_i, rob_br_tag_fix_i,
        input  src_rdy_o, cdb_vld_o, cdb_wr_en_o, cdb_tag_o, cdb_value_o,
               cdb_rob_idx_o, cdb_src_o
    );

    modport slave (
        input  src_vld_i, src_wr_en_i, src_tag_i, src_value_i, src_rob_idx_i,
               src_br_mask_i, rob_br_recovery_i, rob_br_pred_correct_i, rob_br_tag_fix_i,
        output src_rdy_o, cdb_vld_o, cdb_wr_en_o, cdb_tag_o, cdb_value_o,
               cdb_rob_idx_o, cdb_src_o
    );

endinterface

// File: rtl/fu_wb_queue_fifo.sv
// Per-source result FIFO kept head-aligned (slot 0 is the head), so squash
// compaction and pop both reduce to re-packing the surviving entries in order.
module wb_fifo
    import fu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  recovery,
    input  logic                  pred_correct,
    input  logic [`BR_MASK_W-1:0] tag_fix,
    input  wb_entry_t             push_entry,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    wb_entry_t        q     [DEPTH];
    wb_entry_t        q_nxt [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clr;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = q[0];

    always_comb begin
        int        k;
        wb_entry_t e;
        // Recovery takes priority: a resolving branch cannot also clear its bit.
        clr   = pred_correct & ~recovery;
        q_nxt = q;
        k     = 0;
        e     = push_entry;
        for (int j = 0; j < DEPTH; j++) begin
            if ((CNT_W'(j) < cnt) && !(pop && j == 0) &&
                !(recovery && |(q[j].br_mask & tag_fix))) begin
                e = q[j];
                if (clr) e.br_mask = e.br_mask & ~tag_fix;
                q_nxt[IDX_W'(k)] = e;
                k++;
            end
        end
        // The incoming result lands behind every surviving older entry.
        if (push && !(recovery && |(push_entry.br_mask & tag_fix))) begin
            e = push_entry;
            if (clr) e.br_mask = e.br_mask & ~tag_fix;
            if (k < DEPTH) q_nxt[IDX_W'(k)] = e;
            k++;
        end
        cnt_nxt = CNT_W'(k);
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_nxt;
    end

    always_ff @(posedge clk) begin
        q <= q_nxt;
    end

endmodule

// File: rtl/fu_wb_queue.sv
// Writeback completion buffer: per-source FIFOs, round-robin grant onto the
// single CDB, and recovery gating of the broadcast.
module fu_wb_queue
    import fu_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fu_wb_queue_if.slave  wbq
);
    localparam int SRC_W = $clog2(NSRC);

    wb_entry_t        head [NSRC];
    logic [NSRC-1:0]  full;
    logic [NSRC-1:0]  empty;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             cdb_vld;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        wb_entry_t in_entry;

        assign in_entry = '{wr_en:   wbq.src_wr_en_i[i],
                            tag:     wbq.src_tag_i[i],
                            value:   wbq.src_value_i[i],
                            rob_idx: wbq.src_rob_idx_i[i],
                            br_mask: wbq.src_br_mask_i[i]};
        assign push[i] = wbq.src_vld_i[i] & ~full[i];
        assign pop[i]  = cdb_vld && (gnt_idx == SRC_W'(i));

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push         (push[i]),
            .pop          (pop[i]),
            .recovery     (wbq.rob_br_recovery_i),
            .pred_correct (wbq.rob_br_pred_correct_i),
            .tag_fix      (wbq.rob_br_tag_fix_i),
            .push_entry   (in_entry),
            .head         (head[i]),
            .full         (full[i]),
            .empty        (empty[i])
        );
    end

    // Readiness depends only on registered occupancy, never on this cycle's pop.
    assign wbq.src_rdy_o = ~full;

    always_comb begin
        logic [SRC_W-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 0; off < NSRC; off++) begin
            cand = SRC_W'((int'(rr_ptr) + off) % NSRC);
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign cdb_vld           = gnt_vld & ~wbq.rob_br_recovery_i;
    assign wbq.cdb_vld_o     = cdb_vld;
    assign wbq.cdb_wr_en_o   = cdb_vld & head[gnt_idx].wr_en;
    assign wbq.cdb_tag_o     = cdb_vld ? head[gnt_idx].tag     : `ZERO_REG;
    assign wbq.cdb_value_o   = cdb_vld ? head[gnt_idx].value   : 64'd0;
    assign wbq.cdb_rob_idx_o = cdb_vld ? head[gnt_idx].rob_idx : '0;
    assign wbq.cdb_src_o     = cdb_vld ? gnt_idx               : '0;

    always_ff @(posedge clk) begin
        if (!rst)         rr_ptr <= '0;
        else if (cdb_vld) rr_ptr <= (gnt_idx == SRC_W'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: tb/tb_fu_wb_queue.sv
// Directed and randomized checks of fu_wb_queue against a queue-based reference.
module tb_fu_wb_queue;
    import fu_pkg::*;

    localparam int NSRC  = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fu_wb_queue_if #(.NSRC(NSRC)) wbq();

    fu_wb_queue #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wbq (wbq)
    );

    int              tests = 0;
    int              fails = 0;
    wb_entry_t       mq [NSRC][$];
    int              m_rr = 0;
    logic [NSRC-1:0] acc;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic peek();
        if (clk) @(negedge clk);
    endtask

    task automatic clr_in();
        wbq.src_vld_i             = '0;
        wbq.src_wr_en_i           = '0;
        wbq.src_tag_i             = '0;
        wbq.src_value_i           = '0;
        wbq.src_rob_idx_i         = '0;
        wbq.src_br_mask_i         = '0;
        wbq.rob_br_recovery_i     = 1'b0;
        wbq.rob_br_pred_correct_i = 1'b0;
        wbq.rob_br_tag_fix_i      = '0;
    endtask

    task automatic drive(input int i, input logic wr, input int tag, input logic [63:0] val,
                         input int rob, input logic [`BR_MASK_W-1:0] mask);
        wbq.src_vld_i[i]     = 1'b1;
        wbq.src_wr_en_i[i]   = wr;
        wbq.src_tag_i[i]     = `PRF_IDX_W'(tag);
        wbq.src_value_i[i]   = val;
        wbq.src_rob_idx_i[i] = (`ROB_IDX_W+1)'(rob);
        wbq.src_br_mask_i[i] = mask;
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic tick(input bit do_chk);
        int                    g;
        wb_entry_t             e;
        wb_entry_t             kept [$];
        logic [NSRC-1:0]       exp_rdy;
        logic [`BR_MASK_W-1:0] fix;
        peek();
        fix = wbq.rob_br_tag_fix_i;
        g   = -1;
        for (int i = 0; i < NSRC; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
        if (!wbq.rob_br_recovery_i)
            for (int off = 0; off < NSRC; off++)
                if (g < 0 && mq[(m_rr + off) % NSRC].size() > 0) g = (m_rr + off) % NSRC;
        if (do_chk) begin
            chk("src_rdy", 64'(wbq.src_rdy_o), 64'(exp_rdy));
            chk("cdb_vld", 64'(wbq.cdb_vld_o), 64'(g >= 0));
            if (g >= 0) begin
                e = mq[g][0];
                chk("cdb_wr_en", 64'(wbq.cdb_wr_en_o), 64'(e.wr_en));
                chk("cdb_tag", 64'(wbq.cdb_tag_o), 64'(e.tag));
                chk("cdb_value", wbq.cdb_value_o, e.value);
                chk("cdb_rob_idx", 64'(wbq.cdb_rob_idx_o), 64'(e.rob_idx));
                chk("cdb_src", 64'(wbq.cdb_src_o), 64'(g));
            end else begin
                chk("idle_wr_en", 64'(wbq.cdb_wr_en_o), 64'd0);
                chk("idle_tag", 64'(wbq.cdb_tag_o), 64'(`ZERO_REG));
                chk("idle_value", wbq.cdb_value_o, 64'd0);
                chk("idle_rob_idx", 64'(wbq.cdb_rob_idx_o), 64'd0);
                chk("idle_src", 64'(wbq.cdb_src_o), 64'd0);
            end
        end
        acc = wbq.src_vld_i & exp_rdy;
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            if (g >= 0) begin
                void'(mq[g].pop_front());
                m_rr = (g + 1) % NSRC;
            end
            for (int i = 0; i < NSRC; i++) begin
                kept.delete();
                for (int j = 0; j <= mq[i].size(); j++) begin
                    if (j < mq[i].size()) e = mq[i][j];
                    else if (acc[i]) e = '{wr_en: wbq.src_wr_en_i[i], tag: wbq.src_tag_i[i],
                                            value: wbq.src_value_i[i], rob_idx: wbq.src_rob_idx_i[i],
                                            br_mask: wbq.src_br_mask_i[i]};
                    else continue;
                    if (wbq.rob_br_recovery_i) begin
                        if ((e.br_mask & fix) == '0) kept.push_back(e);
                    end else begin
                        if (wbq.rob_br_pred_correct_i) e.br_mask = e.br_mask & ~fix;
                        kept.push_back(e);
                    end
                end
                mq[i] = kept;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int r;
        clr_in();
        rst = 1'b0;
        tick(0);
        tick(0);
        rst = 1'b1;
        peek();
        chk("reset_rdy", 64'(wbq.src_rdy_o), 64'hF);
        chk("reset_vld", 64'(wbq.cdb_vld_o), 64'd0);

        // Single ALU result.
        drive(WB_SRC_ALU, 1'b1, 5, 64'h1234, 3, '0);
        tick(1);
        clr_in();
        peek();
        chk("alu_vld", 64'(wbq.cdb_vld_o), 64'd1);
        chk("alu_wr_en", 64'(wbq.cdb_wr_en_o), 64'd1);
        chk("alu_tag", 64'(wbq.cdb_tag_o), 64'd5);
        chk("alu_value", wbq.cdb_value_o, 64'h1234);
        chk("alu_rob", 64'(wbq.cdb_rob_idx_o), 64'd3);
        tick(1);
        peek();
        chk("alu_gone", 64'(wbq.cdb_vld_o), 64'd0);
        tick(1);

        // Round-robin from rr_ptr = 0.
        rst = 1'b0; tick(1); rst = 1'b1;
        for (int i = 0; i < NSRC; i++) drive(i, 1'b1, 10 + i, 64'(100 + i), i, '0);
        tick(1);
        clr_in();
        for (int i = 0; i < NSRC; i++) begin
            peek();
            chk("rr_grant", 64'(wbq.cdb_src_o), 64'(i));
            tick(1);
        end
        drive(WB_SRC_LDST, 1'b0, 14, 64'h77, 9, '0);
        tick(1);
        clr_in();
        peek();
        chk("rr_ldst_alone", 64'(wbq.cdb_src_o), 64'd2);
        chk("store_no_wr", 64'(wbq.cdb_wr_en_o), 64'd0);
        tick(1);
        drive(WB_SRC_ALU, 1'b1, 15, 64'h88, 10, '0);
        drive(WB_SRC_BR, 1'b1, 16, 64'h99, 11, '0);
        tick(1);
        clr_in();
        peek();
        chk("rr_ptr_at_3", 64'(wbq.cdb_src_o), 64'd3);
        tick(1);
        tick(1);

        // Backpressure: fill FIFOs faster than the CDB drains them.
        rst = 1'b0; tick(1); rst = 1'b1;
        for (int i = 0; i < NSRC; i++) drive(i, 1'b1, 20 + i, 64'(200 + i), i, '0);
        tick(1);
        for (int i = 0; i < NSRC; i++) drive(i, 1'b1, 30 + i, 64'(300 + i), i, '0);
        tick(1);
        clr_in();
        peek();
        chk("bp_rdy", 64'(wbq.src_rdy_o), 64'b0001);
        drive(WB_SRC_MULT, 1'b1, 41, 64'h301, 12, '0);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!acc[1] && n < 20);
        chk("bp_third_accepted", 64'(acc[1]), 64'd1);
        clr_in();
        for (int c = 0; c < 10; c++) tick(1);

        // Squash with a same-cycle matching push.
        rst = 1'b0; tick(1); rst = 1'b1;
        wbq.rob_br_recovery_i = 1'b1;
        drive(WB_SRC_LDST, 1'b1, 40, 64'h40, 4, 4'b0010);
        tick(1);
        drive(WB_SRC_LDST, 1'b1, 41, 64'h41, 5, 4'b0001);
        tick(1);
        wbq.src_vld_i = '0;
        drive(WB_SRC_BR, 1'b1, 42, 64'h42, 6, 4'b0010);
        wbq.rob_br_tag_fix_i = 4'b0010;
        peek();
        chk("sq_vld", 64'(wbq.cdb_vld_o), 64'd0);
        tick(1);
        clr_in();
        peek();
        chk("sq_survivor_src", 64'(wbq.cdb_src_o), 64'd2);
        chk("sq_survivor_val", wbq.cdb_value_o, 64'h41);
        tick(1);
        peek();
        chk("sq_empty", 64'(wbq.cdb_vld_o), 64'd0);
        tick(1);

        // Correct prediction clears a mask bit so a later recovery spares the entry.
        rst = 1'b0; tick(1); rst = 1'b1;
        drive(WB_SRC_ALU, 1'b1, 50, 64'h50, 7, '0);
        drive(WB_SRC_MULT, 1'b1, 51, 64'h51, 8, 4'b0110);
        tick(1);
        clr_in();
        wbq.rob_br_pred_correct_i = 1'b1;
        wbq.rob_br_tag_fix_i      = 4'b0100;
        tick(1);
        wbq.rob_br_pred_correct_i = 1'b0;
        wbq.rob_br_recovery_i     = 1'b1;
        tick(1);
        clr_in();
        peek();
        chk("cp_survivor_src", 64'(wbq.cdb_src_o), 64'd1);
        chk("cp_survivor_val", wbq.cdb_value_o, 64'h51);
        tick(1);

        // Reset with three FIFOs occupied.
        wbq.rob_br_recovery_i = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b1, 60 + i, 64'(600 + i), i, 4'b1000);
        tick(1);
        clr_in();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        peek();
        chk("mid_rst_rdy", 64'(wbq.src_rdy_o), 64'hF);
        chk("mid_rst_vld", 64'(wbq.cdb_vld_o), 64'd0);
        chk("mid_rst_tag", 64'(wbq.cdb_tag_o), 64'(`ZERO_REG));
        chk("mid_rst_src", 64'(wbq.cdb_src_o), 64'd0);
        tick(1);

        // Randomized traffic with branch events and occasional reset.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                wbq.src_vld_i[i]     = 1'($urandom_range(0, 1));
                wbq.src_wr_en_i[i]   = 1'($urandom_range(0, 1));
                wbq.src_tag_i[i]     = `PRF_IDX_W'($urandom);
                wbq.src_value_i[i]   = {$urandom, $urandom};
                wbq.src_rob_idx_i[i] = (`ROB_IDX_W+1)'($urandom);
                wbq.src_br_mask_i[i] = `BR_MASK_W'($urandom_range(0, 15));
            end
            r = int'($urandom_range(0, 7));
            wbq.rob_br_recovery_i     = (r == 0) || (r == 7);
            wbq.rob_br_pred_correct_i = (r == 1) || (r == 7);
            wbq.rob_br_tag_fix_i      = `BR_MASK_W'(1) << $urandom_range(0, `BR_MASK_W - 1);
            rst = ($urandom_range(0, 63) != 0);
            tick(1);
        end
        clr_in();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) tick(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fu_wb_queue.md
# fu_wb_queue

Writeback completion buffer between the functional units and the CDB/ROB/PRF write port. It accepts completed results from NSRC execution sources (ALU, multiplier, load/store, branch), holds each in a small per-source FIFO, and serializes them onto the single CDB. Arbitration is round-robin. Each source gets valid/ready backpressure. Entries carry a branch mask, so the block squashes them on branch recovery and clears mask bits on correct prediction.

## Interface
Parameters:
- NSRC, 4, number of writeback sources; index 0 = ALU, 1 = MULT, 2 = LDST, 3 = BR.
- DEPTH, 2, entries per source FIFO (power of two, ≥2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- src_vld_i  in  NSRC  source i presents a completed result.
- src_rdy_o  out  NSRC  source i FIFO can accept; transfer when vld & rdy.
- src_wr_en_i  in  NSRC  result writes the PRF and broadcasts a tag (0 for stores).
- src_tag_i  in  NSRC×`PRF_IDX_W  destination physical register.
- src_value_i  in  NSRC×64  result value.
- src_rob_idx_i  in  NSRC×(`ROB_IDX_W+1)  ROB entry to mark done.
- src_br_mask_i  in  NSRC×`BR_MASK_W  speculative branch dependence mask.
- rob_br_recovery_i  in  1  mispredict recovery this cycle.
- rob_br_pred_correct_i  in  1  branch resolved correct this cycle.
- rob_br_tag_fix_i  in  `BR_MASK_W  one-hot tag of the resolving branch.
- cdb_vld_o  out  1  a result is on the CDB; the ROB marks cdb_rob_idx_o done.
- cdb_wr_en_o  out  1  PRF write / tag broadcast; never 1 when cdb_vld_o = 0.
- cdb_tag_o  out  `PRF_IDX_W  broadcast tag; `ZERO_REG when not valid.
- cdb_value_o  out  64  write value; 0 when not valid.
- cdb_rob_idx_o  out  `ROB_IDX_W+1  ROB index; 0 when not valid.
- cdb_src_o  out  $clog2(NSRC)  granted source, for debug/perf.

## Operation
- **Enqueue.** Each source has its own FIFO. A push happens when src_vld_i[i] & src_rdy_o[i]. src_rdy_o[i] = ~full[i], computed from registered count only; there is no pop-through.
- **Grant.** Each cycle the arbiter considers all non-empty FIFO heads. It grants the first one at or after rr_ptr, searching cyclically.
  - The granted head drives cdb_* combinationally.
  - The head pops at the clock edge.
  - rr_ptr then advances to grant+1 (mod NSRC). With no grant, rr_ptr holds.
- **Recovery** (rob_br_recovery_i = 1):
  - cdb_vld_o and cdb_wr_en_o are forced to 0 and nothing pops.
  - At the edge, every stored entry with (br_mask & tag_fix) ≠ 0 is invalidated and its FIFO compacted, preserving order.
  - An incoming push with a matching mask is accepted (rdy unchanged) but discarded.
- **Correct prediction** (rob_br_pred_correct_i = 1): at the edge, tag_fix bits are cleared from all stored masks and from same-cycle incoming masks. The CDB operates normally.
- Recovery and correct prediction asserted together: recovery wins; no mask clear.
- Entries with src_wr_en_i = 0 still occupy a CDB slot, so the ROB receives done, but cdb_wr_en_o = 0.

## Timing
- Reset (rst = 0 at an edge) has these effects:
  - all FIFOs empty and rr_ptr = 0;
  - cdb_vld_o = 0, cdb_wr_en_o = 0, cdb_tag_o = `ZERO_REG, cdb_value_o = 0, cdb_rob_idx_o = 0, cdb_src_o = 0;
  - src_rdy_o = all ones from the first cycle after reset;
  - reset overrides a same-cycle push, recovery or grant.
- Latency: a push at edge T appears on the CDB during cycle T+1 at the earliest, with no same-cycle bypass.
- Throughput: one result per cycle total.
- Full FIFO: rdy is 0 during the cycle; a pop at the edge frees rdy for the following cycle.
- A push and a pop on the same FIFO in the same cycle keep the count unchanged. FIFO pointers wrap mod DEPTH.
- Recovery compaction happens in the same edge as that cycle's push. Order is surviving old entries first, then the surviving new entry.

## Structure
- **Package fu_pkg:**
  - wb_entry_t struct with fields wr_en, tag, value, rob_idx, br_mask;
  - source-index constants WB_SRC_ALU/MULT/LDST/BR;
  - the existing `PRF_IDX_W, `ROB_IDX_W, `BR_MASK_W, `ZERO_REG macros.
- **Sub-module wb_fifo:** one instance per source, implementing DEPTH-entry storage with push/pop, mask-squash compaction, mask clear and full/empty.
- **Top:** the round-robin arbiter, CDB output mux and recovery gating.

## Test plan
- **Single ALU result.** Push tag 5, value 0x1234, rob 3 at edge 0. Required: cycle 1 shows cdb_vld_o = 1, cdb_wr_en_o = 1, tag 5, value 0x1234, rob 3. Cycle 2 shows cdb_vld_o = 0.
- **Round-robin.** All 4 sources push one entry in the same cycle, rr_ptr = 0. Required: grants 0, 1, 2, 3 on consecutive cycles. Then source 2 pushes alone: it is granted next and rr_ptr becomes 3.
- **Backpressure.** Source 1 pushes 3 results back-to-back while source 0 is continuously busy.
  - src_rdy_o[1] drops after 2 entries.
  - The third push is held until a pop.
  - All 3 results arrive in order with no loss.
- **Squash.** FIFO 2 holds masks 0b0010 and 0b0001. Recovery with tag_fix 0b0010 and a same-cycle push of mask 0b0010. Required: cdb_vld_o = 0 that cycle, and only the 0b0001 entry remains.
- **Correct prediction.** Stored mask 0b0110, pred_correct with tag_fix 0b0100. Required: the mask becomes 0b0010. A later recovery on 0b0100 does not squash the entry.
- **Reset mid-operation.** rst = 0 with 3 FIFOs non-empty. Required: next cycle all outputs are at their reset values and src_rdy_o = 1111.
